// File: rtl/versat_const_seq_pkg.sv
// Shared types and defaults for the Versat constant-sequence source unit.
// Optional ramp feature: VERSAT_CONST_SEQ_RAMP_EN.
package versat_const_seq_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_HOLD_W  = 8;
    localparam int DEF_DELAY_W = 10;
    localparam int DEF_ITER_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        GEN   = 2'd2
    } state_t;

    function automatic int len_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/versat_hold_counter.sv
// Loadable down-counter; tc pulses while enabled and the count is zero.
// Used for both the start delay and the per-entry hold.
module versat_hold_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = en && (count == '0);

endmodule

// File: rtl/versat_const_seq.sv
// Constant-sequence source: plays a table of constants with delay/hold/passes.
// Define VERSAT_CONST_SEQ_RAMP_EN to add a per-pass offset (cfg_incr).
module versat_const_seq
    import versat_const_seq_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int HOLD_W  = DEF_HOLD_W,
    parameter int DELAY_W = DEF_DELAY_W,
    parameter int ITER_W  = DEF_ITER_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    input  logic [DEPTH*DATA_W-1:0]   cfg_const,
    input  logic [len_w(DEPTH)-1:0]   cfg_len,
    input  logic [HOLD_W-1:0]         cfg_hold,
    input  logic [DELAY_W-1:0]        cfg_delay,
    input  logic [ITER_W-1:0]         cfg_iter,
`ifdef VERSAT_CONST_SEQ_RAMP_EN
    input  logic [DATA_W-1:0]         cfg_incr,
`endif
    output logic [DATA_W-1:0]         out0,
    output logic                      done
);

    localparam int LEN_W = len_w(DEPTH);

    state_t state, state_next;

    logic [DEPTH*DATA_W-1:0] tbl_sh;
    logic [LEN_W-1:0]        len_sh;
    logic [HOLD_W-1:0]       hold_sh;
    logic [ITER_W-1:0]       iter_sh;
    logic [LEN_W-1:0]        idx;
    logic [ITER_W-1:0]       pass;

    logic [LEN_W-1:0]  len_clamp;
    logic [HOLD_W-1:0] cfg_hold_m1;
    logic [HOLD_W-1:0] hold_m1;
    logic [LEN_W-1:0]  idx_n;
    logic [DATA_W-1:0] entry_n;
    logic [DATA_W-1:0] offset_cur;
    logic [DATA_W-1:0] offset_wrap;

    logic start_gen;
    logic step;
    logic wrap;
    logic delay_tc;
    logic hold_tc;
    logic hold_load;

    assign len_clamp = (cfg_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : cfg_len;

    // A hold of zero behaves as one; counters load hold-1.
    assign cfg_hold_m1 = (cfg_hold == '0) ? '0 : cfg_hold - 1'b1;
    assign hold_m1     = (hold_sh == '0) ? '0 : hold_sh - 1'b1;

    assign hold_load = run || start_gen || step;
    assign done      = (state == IDLE);

    versat_hold_counter #(
        .W(DELAY_W)
    ) u_delay_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (run),
        .value(cfg_delay - 1'b1),
        .en   (state == DELAY),
        .tc   (delay_tc)
    );

    versat_hold_counter #(
        .W(HOLD_W)
    ) u_hold_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (hold_load),
        .value(run ? cfg_hold_m1 : hold_m1),
        .en   (state == GEN),
        .tc   (hold_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_gen  = 1'b0;
        step       = 1'b0;
        wrap       = 1'b0;
        if (run) begin
            // An empty table still spends one cycle in GEN so done dips low.
            if (len_clamp == '0) begin
                state_next = GEN;
            end else if (cfg_delay != '0) begin
                state_next = DELAY;
            end else begin
                state_next = GEN;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    state_next = IDLE;
                end
                DELAY: begin
                    if (delay_tc) begin
                        state_next = GEN;
                        start_gen  = 1'b1;
                    end
                end
                GEN: begin
                    if (len_sh == '0) begin
                        state_next = IDLE;
                    end else if (hold_tc) begin
                        if (idx == len_sh - 1'b1) begin
                            wrap = 1'b1;
                            if (iter_sh != '0 && pass + 1'b1 == iter_sh) begin
                                state_next = IDLE;
                            end else begin
                                step = 1'b1;
                            end
                        end else begin
                            step = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign idx_n = (start_gen || wrap) ? '0 : idx + 1'b1;

    always_comb begin
        entry_n = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (idx_n == LEN_W'(k)) begin
                entry_n = tbl_sh[k*DATA_W +: DATA_W];
            end
        end
    end

`ifdef VERSAT_CONST_SEQ_RAMP_EN
    logic [DATA_W-1:0] incr_sh;
    logic [DATA_W-1:0] offset;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            incr_sh <= '0;
            offset  <= '0;
        end else if (run) begin
            incr_sh <= cfg_incr;
            offset  <= '0;
        end else if (wrap) begin
            offset <= offset + incr_sh;
        end
    end

    assign offset_cur  = offset;
    assign offset_wrap = offset + incr_sh;
`else
    assign offset_cur  = '0;
    assign offset_wrap = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tbl_sh  <= '0;
            len_sh  <= '0;
            hold_sh <= '0;
            iter_sh <= '0;
            idx     <= '0;
            pass    <= '0;
            out0    <= '0;
        end else if (run) begin
            tbl_sh  <= cfg_const;
            len_sh  <= len_clamp;
            hold_sh <= cfg_hold;
            iter_sh <= cfg_iter;
            idx     <= '0;
            pass    <= '0;
            // Zero delay: entry 0 must be visible the cycle after run.
            if (len_clamp != '0 && cfg_delay == '0) begin
                out0 <= cfg_const[DATA_W-1:0];
            end
        end else begin
            if (start_gen || step) begin
                idx  <= idx_n;
                out0 <= entry_n + (wrap ? offset_wrap : offset_cur);
            end
            if (wrap) begin
                pass <= pass + 1'b1;
            end
        end
    end

endmodule

// File: doc/versat_const_seq.md
# versat_const_seq

Parametrised constant-sequence source unit for the Versat datapath. It generalises the single static constant into a table of up to DEPTH constants. Each entry is held on `out0` for a programmable number of cycles, after an initial delay, for a programmable number of passes. The unit sits in the accelerator's functional-unit array, driven by the global `run`/`done` handshake, with its configuration coming from the unit's configuration registers.

## Interface
Parameters:
- `DATA_W`, 32, width of each constant and of `out0`
- `DEPTH`, 4, number of table entries (≥1)
- `HOLD_W`, 8, width of the hold-count field
- `DELAY_W`, 10, width of the start-delay field
- `ITER_W`, 8, width of the pass-count field

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `run`  in  1  one-cycle start pulse; configuration sampled on this cycle
- `cfg_const`  in  DEPTH*DATA_W  table; entry k at bits [k*DATA_W +: DATA_W]
- `cfg_len`  in  $clog2(DEPTH+1)  number of entries used
- `cfg_hold`  in  HOLD_W  cycles each entry is held; 0 treated as 1
- `cfg_delay`  in  DELAY_W  cycles from `run` to the first entry
- `cfg_iter`  in  ITER_W  passes through the table; 0 = free-running
- `out0`  out  DATA_W  current constant
- `done`  out  1  high when idle

## Operation
- States: IDLE, DELAY, GEN.
- IDLE: `done`=1 and `out0` holds its last value.
- `run` in any state latches all cfg_* into shadow registers, resets the entry index, hold counter and pass counter, and drops `done` the following cycle.
  - If the latched `cfg_delay`>0, the next state is DELAY. Otherwise it is GEN.
- DELAY: counts `cfg_delay` cycles, then enters GEN. `out0` is unchanged during DELAY.
- GEN: `out0` = entry[idx]. After `hold` cycles, idx increments.
  - When idx reaches len-1 and its hold expires, idx wraps to 0 and the pass counter increments.
  - When the pass counter equals `cfg_iter` (non-zero), the unit enters IDLE.
- Free-running (`cfg_iter`=0): GEN continues until reset or the next `run`.
- `cfg_len`=0: `run` is a no-op apart from a one-cycle `done` low. The unit returns to IDLE with `out0` unchanged.
- `cfg_len`>DEPTH: clamped to DEPTH.
- `run` during DELAY or GEN: the current sequence is abandoned and the unit restarts with the new configuration. No residual state carries over.
- Reset mid-operation: immediate return to IDLE with reset values.
- Changes to cfg_* inputs while busy have no effect until the next `run`.

## Timing
- Reset values: `out0`=0, `done`=1, state=IDLE, all counters 0.
- With `run` at cycle t and delay D:
  - `done`=0 from t+1.
  - `out0`=entry[0] from t+1+D.
- Each entry is visible for exactly max(hold,1) consecutive cycles.
- A finite run lasts len·max(hold,1)·iter cycles of GEN. `done` rises the cycle after the last GEN cycle.
- `out0` is registered; there is no combinational path from any input to any output.
- Back-to-back: `run` in the same cycle that `done` would rise takes priority, so `done` stays 0.

## Configuration
- Macro `VERSAT_CONST_SEQ_RAMP_EN`.
- Defined:
  - Adds input port `cfg_incr` (DATA_W).
  - An offset register, cleared on `run`, adds `cfg_incr` at each pass wrap.
  - `out0` = entry[idx] + offset, with modulo 2^DATA_W wrap-around.
- Undefined: the port is absent, no offset register exists, and `out0` = entry[idx].

## Structure
- Shared package `versat_const_seq_pkg` holds:
  - state encodings (IDLE=0, DELAY=1, GEN=2)
  - the width helper for `cfg_len`
  - default parameter values
- One sub-module, `versat_hold_counter`: a loadable down-counter with a terminal-count pulse. It is instantiated twice, once for the delay and once for the hold.
- The table is not copied into storage beyond the shadow register. Entry selection is a DEPTH:1 multiplexer on the shadow table.

## Test plan
- Reset: assert `rst`=0 mid-GEN → `out0`=0 and `done`=1 immediately; after release, stays IDLE with no `run`.
- Basic sequence: DEPTH=4, table {5,6,7,8}, len=3, hold=2, delay=0, iter=2, `run` at t → `out0` shows 5,5,6,6,7,7,5,5,6,6,7,7 from t+1; `done`=1 at t+13.
- Delay and hold zero: delay=3, hold=0, len=2, table {0xA,0xB}, iter=1 → `out0` is unchanged for t+1..t+3, then 0xA at t+4 and 0xB at t+5; `done`=1 at t+6.
- Boundaries:
  - len=0 → `done` low for one cycle only and `out0` unchanged.
  - len=7 with DEPTH=4 → behaves as len=4.
- Restart and free-run: iter=0, table {1,2}, hold=1 → alternates 1,2 indefinitely. A second `run` with table {9} → 9 from the next cycle onward, and `done` stays 0.
- Ramp (`VERSAT_CONST_SEQ_RAMP_EN`): table {0xFFFFFFFE}, len=1, hold=1, iter=3, incr=1 → `out0` shows 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
